// File: rtl/restador_sync.sv
// Registered WIDTH-bit subtractor: restador = minuendo - sustraendo, built as
// minuendo + ~sustraendo + 1 on a ripple chain, with carry, zero and overflow flags.
module restador_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] minuendo,
    input  logic [WIDTH-1:0] sustraendo,
    output logic             out_valid,
    output logic [WIDTH-1:0] restador,
    output logic             C_out,
    output logic             zero,
    output logic             overflow
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sustraendo_inv;
    logic [WIDTH-1:0] diff_next;
    logic             zero_next;
    logic             overflow_next;

    logic             out_valid_reg;
    logic [WIDTH-1:0] restador_reg;
    logic             c_out_reg;
    logic             zero_reg;
    logic             overflow_reg;

    // Carry-in of 1 supplies the "+1" of the two's-complement negation.
    assign carry[0]       = 1'b1;
    assign sustraendo_inv = ~sustraendo;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign diff_next[gi] = minuendo[gi] ^ sustraendo_inv[gi] ^ carry[gi];
            assign carry[gi+1]   = (minuendo[gi] & sustraendo_inv[gi])
                                 | (carry[gi] & (minuendo[gi] ^ sustraendo_inv[gi]));
        end
    endgenerate

    assign zero_next     = (diff_next == '0);
    assign overflow_next = (minuendo[MSB] != sustraendo[MSB]) && (diff_next[MSB] != minuendo[MSB]);

    // Result and flags only load on valid, so garbage operands while idle are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            restador_reg  <= '0;
            c_out_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                restador_reg <= diff_next;
                c_out_reg    <= carry[WIDTH];
                zero_reg     <= zero_next;
                overflow_reg <= overflow_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign restador  = restador_reg;
    assign C_out     = c_out_reg;
    assign zero      = zero_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_restador_sync.sv
// Directed bench for restador_sync (WIDTH=5): reset, sweep, extremes, overflow,
// hold behaviour and reset in the middle of a stream.
module tb_restador_sync;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] minuendo = '0;
    logic [W-1:0] sustraendo = '0;
    logic         out_valid;
    logic [W-1:0] restador;
    logic         C_out;
    logic         zero;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    restador_sync #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .minuendo   (minuendo),
        .sustraendo (sustraendo),
        .out_valid  (out_valid),
        .restador   (restador),
        .C_out      (C_out),
        .zero       (zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int v, input int r, input int c,
                             input int z, input int o);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".restador"},  32'(restador),  32'(r));
        check({tag, ".C_out"},     32'(C_out),     32'(c));
        check({tag, ".zero"},      32'(zero),      32'(z));
        check({tag, ".overflow"},  32'(overflow),  32'(o));
        $display("%s: A=%0d B=%0d -> valid=%0d restador=%0d C_out=%0d zero=%0d ovf=%0d",
                 tag, minuendo, sustraendo, out_valid, restador, C_out, zero, overflow);
    endtask

    // Present one operand pair at a falling edge, then sample after the next rising edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid   = 1'b1;
        minuendo   = a;
        sustraendo = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset applied asynchronously while operands are valid.
        in_valid   = 1'b1;
        minuendo   = 5'd7;
        sustraendo = 5'd3;
        #2 rst_n = 1'b0;
        #1 check_all("reset_async", 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check_all("reset_held", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all("reset_release", 1, 4, 1, 0, 0);

        // A=1, B=0..14 back to back.
        for (int b = 0; b <= 14; b++) begin
            do_op(5'd1, 5'(b));
            check_all($sformatf("sweep_b%0d", b), 1,
                      (b <= 1) ? (1 - b) : (33 - b),
                      (b <= 1) ? 1 : 0,
                      (b == 1) ? 1 : 0,
                      0);
        end

        do_op(5'd31, 5'd0);  check_all("ext_31_0",  1, 31, 1, 0, 0);
        do_op(5'd0,  5'd31); check_all("ext_0_31",  1, 1,  0, 0, 0);
        do_op(5'd16, 5'd1);  check_all("ovf_16_1",  1, 15, 1, 0, 1);
        do_op(5'd15, 5'd31); check_all("ovf_15_31", 1, 16, 0, 0, 1);
        do_op(5'd21, 5'd21); check_all("eq_21_21",  1, 0,  1, 1, 0);
        do_op(5'd0,  5'd0);  check_all("eq_0_0",    1, 0,  1, 1, 0);
        do_op(5'd12, 5'd0);  check_all("bzero_12",  1, 12, 1, 0, 0);

        // Hold: result stays while idle, even with changing or unknown operands.
        do_op(5'd9, 5'd4);   check_all("hold_load", 1, 5, 1, 0, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            minuendo   = (i == 1) ? 5'bxxxxx : 5'(i + 20);
            sustraendo = (i == 1) ? 5'bxxxxx : 5'(i * 7);
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("hold_idle%0d", i), 0, 5, 1, 0, 0);
        end

        // Reset between edges while a valid pair is pending.
        do_op(5'd10, 5'd3);  check_all("mid_pre", 1, 7, 1, 0, 0);
        in_valid   = 1'b1;
        minuendo   = 5'd20;
        sustraendo = 5'd5;
        #2 rst_n = 1'b0;
        #1 check_all("mid_async", 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check_all("mid_held", 0, 0, 0, 0, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all("mid_release_idle", 0, 0, 0, 0, 0);
        do_op(5'd6, 5'd2);   check_all("mid_first", 1, 4, 1, 0, 0);
        do_op(5'd3, 5'd5);   check_all("mid_second", 1, 30, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/restador_sync.md
Name: restador_sync

Overview:
- Registered WIDTH-bit unsigned/two's-complement subtractor: restador = minuendo − sustraendo, computed as minuendo + ~sustraendo + 1.
- Provides a carry-out (C_out) plus status flags.
- Sits in the arithmetic datapath as the subtraction unit alongside the adder.
- One-cycle registered latency with a valid qualifier.

Parameters:
- WIDTH, 5, operand and result width in bits (legal ≥ 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- minuendo  input  WIDTH  minuend A
- sustraendo  input  WIDTH  subtrahend B
- out_valid  output  1  result registers hold a new result
- restador  output  WIDTH  difference (A − B) mod 2^WIDTH
- C_out  output  1  carry-out of A + ~B + 1; 1 = no borrow (A ≥ B unsigned), 0 = borrow
- zero  output  1  restador == 0
- overflow  output  1  signed overflow: A[MSB] != B[MSB] and result MSB != A[MSB]

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset: rst_n low immediately forces the following outputs, independent of clk:
  - out_valid = 0
  - restador = 0
  - C_out = 0
  - zero = 0
  - overflow = 0
- Reset release: first capture happens on the first rising clk edge with rst_n high.
- Datapath:
  - Ripple chain of WIDTH full-adder cells on A and ~B, carry-in fixed at 1.
  - Carry out of the top cell is C_out.
  - Purely combinational between the input ports and the output registers; no state other than the output registers.
- Capture, on each rising edge with rst_n high:
  - When in_valid = 1: restador, C_out, zero and overflow load from the current operands, and out_valid ← 1.
  - When in_valid = 0: out_valid ← 0, and restador and all flags hold their previous values.
- Latency: result for operands presented at edge N appears after edge N, stable through edge N+1. Back-to-back in_valid is accepted every cycle; there is no stall and no backpressure.
- Width rules:
  - Result wraps modulo 2^WIDTH.
  - No sign extension.
  - Unsigned interpretation drives C_out; signed interpretation drives overflow.
- Boundary conditions:
  - A == B → restador 0, zero 1, C_out 1, overflow 0.
  - A < B unsigned → wrap-around result, C_out 0.
  - B == 0 → restador = A, C_out 1, overflow 0.
  - A = 0, B = 0 → restador 0, C_out 1, zero 1.
  - Signed overflow, e.g. WIDTH=5, A=16 (−16), B=1 → restador 15, overflow 1, C_out 1.
- Reset mid-operation: asserting rst_n while in_valid is high discards the pending capture. Outputs go to their reset values immediately and stay there until the first edge after release.
- X on the operands while in_valid = 0 must not disturb the held outputs.

Test Plan:
- Reset: rst_n low with in_valid=1, A=7, B=3 → all outputs 0 immediately without a clock edge. Release, then one edge → restador 4, C_out 1, zero 0, out_valid 1.
- Sweep, WIDTH=5: A=1, B=0..14, in_valid=1 each cycle. Required values one cycle after each operand pair:
  - B=0 → restador 1, C_out 1.
  - B=1 → restador 0, zero 1, C_out 1.
  - B=2 → restador 31, C_out 0.
  - B=14 → restador 19, C_out 0.
- Extremes: A=31, B=0 → restador 31, C_out 1. Then A=0, B=31 → restador 1, C_out 0.
- Signed overflow: A=16, B=1 → restador 15, overflow 1. Then A=15, B=31 → restador 16, overflow 1.
- Hold and valid: in_valid=1 with A=9, B=4 → restador 5. Then in_valid=0 while A and B change → out_valid 0 and restador stays 5 for multiple cycles.
- Reset mid-stream: back-to-back valid operands, assert rst_n between edges → outputs clear at once, and the next result appears only after release plus one valid edge.
